rtc_edit_keypad: RTL and testbench

Front-end conditioning and field-selection stage that drives the RTC edit-value counter. It synchronises and debounces four raw push-buttons. It tracks which RTC field is being edited and emits the 4-bit field code that the counter consumes. It also emits stretched increment/decrement requests long enough to be caught by the counter's slow (~5 Hz) internal clock.

---
 rtl/rtc_edit_keypad.sv | 141 ++++++++++++++
 tb/tb_rtc_edit_keypad.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_edit_keypad.sv
// rtc_edit_keypad: debounced keypad -> RTC edit field code plus stretched up/down requests.
// Define RTC_KEYPAD_AUTOREPEAT_EN to compile hold-to-repeat for up/down.
module rtc_edit_keypad #(
  parameter int DB_CYCLES    = 2_000_000,
  parameter int PULSE_CYCLES = 20_000_000,
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int RPT_CYCLES   = 20_000_000,
  parameter int NUM_FIELDS   = 9
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       btn_edit_i,
  input  logic       btn_next_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  output logic [3:0] cambio_o,
  output logic       aumenta_o,
  output logic       disminuye_o,
  output logic       edit_o,
  output logic       commit_o
);
  localparam int DW = $clog2(DB_CYCLES);
  localparam int PW = $clog2(PULSE_CYCLES);
  typedef enum logic {S_IDLE, S_EDIT} state_t;
  typedef enum logic [1:0] {P_IDLE, P_HIGH, P_GUARD} phase_t;
  logic [3:0] raw, s1_q, s2_q, db_q, dbp_q, press, cambio_q, cambio_d;
  logic [DW-1:0] dcnt_q [4];
  state_t state_q;
  phase_t phase_q;
  logic [PW-1:0] pcnt_q;
  logic commit_q, aum_q, dis_q;
  logic ev_next, fchg, ud_ok, rpt_up, rpt_dn, up_t, dn_t, ev_up, ev_dn, fire;
  assign raw      = {btn_down_i, btn_up_i, btn_next_i, btn_edit_i};
  assign press    = db_q & ~dbp_q;
  assign ev_next  = press[1] & ~press[0] & (state_q == S_EDIT);
  assign fchg     = press[0] | ev_next;
  assign ud_ok    = (state_q == S_EDIT) & ~press[0] & ~press[1];
  assign up_t     = press[2] | rpt_up;
  assign dn_t     = press[3] | rpt_dn;
  assign ev_up    = ud_ok & up_t & ~dn_t;
  assign ev_dn    = ud_ok & dn_t & ~up_t;
  // the last guard cycle already counts as free so the busy window is exactly 2*PULSE_CYCLES
  assign fire     = (ev_up | ev_dn) &
                    ((phase_q == P_IDLE) | ((phase_q == P_GUARD) & (pcnt_q == PW'(PULSE_CYCLES - 1))));
  assign cambio_d = press[0] ? ((state_q == S_IDLE) ? 4'd1 : 4'd0) :
                    ev_next  ? ((cambio_q == 4'(NUM_FIELDS)) ? 4'd1 : cambio_q + 4'd1) : cambio_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q  <= '0;
      s2_q  <= '0;
      db_q  <= '0;
      dbp_q <= '0;
      for (int i = 0; i < 4; i++) dcnt_q[i] <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      dbp_q <= db_q;
      for (int i = 0; i < 4; i++) begin
        if (s2_q[i] == db_q[i]) dcnt_q[i] <= '0;
        else if (dcnt_q[i] == DW'(DB_CYCLES - 1)) begin
          db_q[i]   <= s2_q[i];
          dcnt_q[i] <= '0;
        end else dcnt_q[i] <= dcnt_q[i] + DW'(1);
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cambio_q <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= press[0] ? ((state_q == S_IDLE) ? S_EDIT : S_IDLE) : state_q;
      cambio_q <= cambio_d;
      commit_q <= press[0] & (state_q == S_EDIT);
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase_q <= P_IDLE;
      pcnt_q  <= '0;
      aum_q   <= 1'b0;
      dis_q   <= 1'b0;
    end else if (fchg && phase_q == P_HIGH) begin
      phase_q <= P_GUARD;
      pcnt_q  <= '0;
      aum_q   <= 1'b0;
      dis_q   <= 1'b0;
    end else if (fire) begin
      phase_q <= P_HIGH;
      pcnt_q  <= '0;
      aum_q   <= ev_up;
      dis_q   <= ev_dn;
    end else if (phase_q != P_IDLE) begin
      if (pcnt_q == PW'(PULSE_CYCLES - 1)) begin
        phase_q <= (phase_q == P_HIGH) ? P_GUARD : P_IDLE;
        pcnt_q  <= '0;
        aum_q   <= 1'b0;
        dis_q   <= 1'b0;
      end else pcnt_q <= pcnt_q + PW'(1);
    end
  end
`ifdef RTC_KEYPAD_AUTOREPEAT_EN
  localparam int HW = $clog2((HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES);
  logic hact_q, hdir_q, hrep_q, hlvl, tick;
  logic [HW-1:0] hcnt_q;
  assign hlvl   = hdir_q ? db_q[3] : db_q[2];
  assign tick   = hact_q & hlvl &
                  (hcnt_q == (hrep_q ? HW'(RPT_CYCLES - 1) : HW'(HOLD_CYCLES - 1)));
  assign rpt_up = tick & ~hdir_q;
  assign rpt_dn = tick & hdir_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hact_q <= 1'b0;
      hdir_q <= 1'b0;
      hrep_q <= 1'b0;
      hcnt_q <= '0;
    end else if (fchg) hact_q <= 1'b0;
    else if (ud_ok && (press[2] ^ press[3])) begin
      hact_q <= 1'b1;
      hdir_q <= press[3];
      hrep_q <= 1'b0;
      hcnt_q <= '0;
    end else if (hact_q) begin
      if (!hlvl) hact_q <= 1'b0;
      else if (tick) begin
        hrep_q <= 1'b1;
        hcnt_q <= '0;
      end else hcnt_q <= hcnt_q + HW'(1);
    end
  end
`else
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif
  assign cambio_o    = cambio_q;
  assign edit_o      = (state_q == S_EDIT);
  assign commit_o    = commit_q;
  assign aumenta_o   = aum_q;
  assign disminuye_o = dis_q;
endmodule

// File: tb/tb_rtc_edit_keypad.sv
// tb_rtc_edit_keypad: directed + random stimulus against an event/timestamp reference model.
module tb_rtc_edit_keypad;
  localparam int DB = 4, P = 5, H = 40, R = 12, NF = 9;
`ifdef RTC_KEYPAD_AUTOREPEAT_EN
  localparam int HOLD_EXP = 6;
`else
  localparam int HOLD_EXP = 1;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] raw = '0;
  logic [3:0] cambio_o;
  logic aumenta_o, disminuye_o, edit_o, commit_o;
  always #5 clk = ~clk;
  rtc_edit_keypad #(.DB_CYCLES(DB), .PULSE_CYCLES(P), .HOLD_CYCLES(H), .RPT_CYCLES(R), .NUM_FIELDS(NF)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .btn_edit_i(raw[0]), .btn_next_i(raw[1]), .btn_up_i(raw[2]), .btn_down_i(raw[3]),
    .cambio_o(cambio_o), .aumenta_o(aumenta_o), .disminuye_o(disminuye_o),
    .edit_o(edit_o), .commit_o(commit_o)
  );
  int n_err = 0, n_chk = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // reference model: button levels, field number, and timestamps for pulse/busy/repeat windows
  bit [3:0] m_s1, m_s2, m_lvl, m_prev;
  int m_run[4];
  int m_field, n_edge, p_dir, hi_until, busy_until, h_dir, next_rpt;
  bit m_commit, m_aum, m_dis, h_on;
  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_field = 0; p_dir = 0; hi_until = 0; busy_until = 0;
    h_on = 0; h_dir = 0; next_rpt = 0;
    m_commit = 0; m_aum = 0; m_dis = 0;
  endtask
  task automatic model_edge(input bit [3:0] r);
    bit [3:0] pr;
    bit ev_e, ev_n, fchg, udok, rpt_u, rpt_d, upt, dnt, ev, lvl_h;
    n_edge++;
    pr    = m_lvl & ~m_prev;
    ev_e  = pr[0];
    ev_n  = pr[1] && !pr[0] && m_field != 0;
    fchg  = ev_e || ev_n;
    udok  = m_field != 0 && !pr[0] && !pr[1];
    lvl_h = m_lvl[2 + h_dir];
    rpt_u = 0;
    rpt_d = 0;
`ifdef RTC_KEYPAD_AUTOREPEAT_EN
    if (h_on && lvl_h && n_edge == next_rpt) begin
      if (h_dir == 0) rpt_u = 1;
      else rpt_d = 1;
    end
`endif
    upt = pr[2] | rpt_u;
    dnt = pr[3] | rpt_d;
    ev  = udok && (upt != dnt);
    if (fchg && (m_aum || m_dis)) begin
      hi_until   = n_edge;
      busy_until = n_edge + P;
    end else if (ev && n_edge >= busy_until) begin
      p_dir      = upt ? 1 : 2;
      hi_until   = n_edge + P;
      busy_until = n_edge + 2 * P;
    end
    m_aum    = p_dir == 1 && n_edge < hi_until;
    m_dis    = p_dir == 2 && n_edge < hi_until;
    m_commit = ev_e && m_field != 0;
    if (ev_e) m_field = (m_field == 0) ? 1 : 0;
    else if (ev_n) m_field = (m_field == NF) ? 1 : m_field + 1;
`ifdef RTC_KEYPAD_AUTOREPEAT_EN
    if (fchg) h_on = 0;
    else if (udok && pr[2] != pr[3]) begin
      h_on = 1;
      h_dir = pr[3] ? 1 : 0;
      next_rpt = n_edge + H;
    end else if (h_on) begin
      if (!lvl_h) h_on = 0;
      else if (n_edge == next_rpt) next_rpt += R;
    end
`endif
    m_prev = m_lvl;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else m_run[i] = 0;
    end
    m_s2 = m_s1;
    m_s1 = r;
  endtask
  int up_rise, dn_rise, up_hi, commit_cnt, abort_seen;
  bit last_aum, last_dis, watch_abort;
  logic [3:0] last_cambio;
  task automatic step(input bit [3:0] r);
    raw = r;
    model_edge(r);
    @(negedge clk);
    check("cambio", cambio_o, m_field);
    check("edit", edit_o, m_field != 0);
    check("commit", commit_o, m_commit);
    check("aumenta", aumenta_o, m_aum);
    check("disminuye", disminuye_o, m_dis);
    if (aumenta_o && !last_aum) up_rise++;
    if (aumenta_o) up_hi++;
    if (disminuye_o && !last_dis) dn_rise++;
    if (commit_o) commit_cnt++;
    if (watch_abort && cambio_o !== last_cambio) begin
      check("abort_prev_aum", last_aum, 1);
      check("abort_aum", aumenta_o, 0);
      abort_seen++;
      watch_abort = 0;
    end
    last_aum = aumenta_o;
    last_dis = disminuye_o;
    last_cambio = cambio_o;
  endtask
  task automatic run(input bit [3:0] r, input int k);
    repeat (k) step(r);
  endtask
  task automatic clr();
    up_rise = 0; dn_rise = 0; up_hi = 0; commit_cnt = 0; abort_seen = 0;
  endtask
  initial begin
    int lat;
    bit [3:0] r;
    n_edge = 0;
    model_reset();
    clr();
    last_aum = 0; last_dis = 0; last_cambio = '0; watch_abort = 0;
    repeat (3) @(negedge clk);
    check("rst_cambio", cambio_o, 0);
    check("rst_edit", edit_o, 0);
    check("rst_commit", commit_o, 0);
    check("rst_aum", aumenta_o, 0);
    check("rst_dis", disminuye_o, 0);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step(4'b0001);
      if (edit_o === 1'b1 && lat == 0) lat = i;
    end
    check("edit_latency", lat, 7);
    check("edit_field", cambio_o, 1);
    run(4'b0000, 10);
    run(4'b0010, 3);
    run(4'b0000, 10);
    check("glitch_field", cambio_o, 1);
    for (int k = 1; k <= 9; k++) begin
      run(4'b0010, 6);
      run(4'b0000, 6);
      check("next_field", cambio_o, (k == 9) ? 1 : k + 1);
    end
    clr();
    run(4'b0001, 6);
    run(4'b0000, 6);
    check("commit_cnt", commit_cnt, 1);
    check("commit_field", cambio_o, 0);
    run(4'b0001, 6);
    run(4'b0000, 6);
    check("reenter_field", cambio_o, 1);
    clr();
    run(4'b0100, 5);
    run(4'b0000, 4);
    run(4'b0100, 5);
    run(4'b0000, 25);
    check("dup_up_rise", up_rise, 1);
    check("up_hi_len", up_hi, P);
    check("dup_dn_rise", dn_rise, 0);
    clr();
    run(4'b0100, 8);
    run(4'b0000, 3);
    run(4'b0100, 8);
    run(4'b0000, 25);
    check("repress_rise", up_rise, 1);
    clr();
    run(4'b0100, 100);
    run(4'b0000, 30);
    check("hold_rise", up_rise, HOLD_EXP);
    check("hold_dn_rise", dn_rise, 0);
    clr();
    run(4'b1100, 8);
    run(4'b0000, 25);
    check("both_up", up_rise, 0);
    check("both_dn", dn_rise, 0);
    clr();
    watch_abort = 1;
    run(4'b0100, 2);
    run(4'b0110, 6);
    run(4'b0000, 25);
    watch_abort = 0;
    check("abort_seen", abort_seen, 1);
    check("abort_field", cambio_o, 2);
    run(4'b0100, 8);
    check("pre_rst_aum", aumenta_o, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_cambio", cambio_o, 0);
    check("arst_edit", edit_o, 0);
    check("arst_commit", commit_o, 0);
    check("arst_aum", aumenta_o, 0);
    check("arst_dis", disminuye_o, 0);
    raw = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    last_aum = 0; last_dis = 0; last_cambio = '0;
    run(4'b0001, 6);
    run(4'b0000, 6);
    for (int it = 0; it < 250; it++) begin
      r = 4'($urandom_range(0, 15));
      r[0] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) r = '0;
      run(r, ($urandom_range(0, 4) == 0) ? int'($urandom_range(30, 70)) : int'($urandom_range(1, 10)));
    end
    run(4'b0000, 30);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
